// File: rtl/mem_arb_pkg.sv
// Shared types and tag helpers for the system-bus request arbiter.
// Tag header layout (MSBs of the bus tag): {rw, owner[1:0]}; remaining tag bits are zero.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_FETCH = 2'd0,
        OWN_LOAD  = 2'd1,
        OWN_STORE = 2'd2
    } owner_e;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WR_DATA,
        RD_WAIT,
        DONE
    } state_e;

    localparam int TAG_HDR_W = 3;

    function automatic logic [TAG_HDR_W-1:0] make_tag(input logic rw, input owner_e owner);
        return {rw, owner};
    endfunction

    // Completion / read-valid vectors are ordered {fetch, load, store}.
    function automatic logic [2:0] owner_onehot(input owner_e owner);
        logic [2:0] oh;
        case (owner)
            OWN_FETCH: oh = 3'b100;
            OWN_LOAD:  oh = 3'b010;
            OWN_STORE: oh = 3'b001;
            default:   oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Requester priority pick (store > load > fetch) with an anti-starvation override for fetch.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIM = 4
) (
    input  logic   clk,
    input  logic   srst,
    input  logic   arb_en,
    input  logic   fetch_req,
    input  logic   load_req,
    input  logic   store_req,
    output owner_e owner,
    output logic   grant
);

    localparam int CNT_W = $clog2(STARVE_LIM + 1);

    logic [CNT_W-1:0] starve_q;
    logic [CNT_W-1:0] starve_d;
    logic             starved;

    assign starved = (starve_q == CNT_W'(STARVE_LIM));

    always_comb begin
        grant    = arb_en && (fetch_req || load_req || store_req);
        owner    = OWN_FETCH;
        starve_d = starve_q;
        if (starved && fetch_req) begin
            owner = OWN_FETCH;
        end else if (store_req) begin
            owner = OWN_STORE;
        end else if (load_req) begin
            owner = OWN_LOAD;
        end
        // Only grants that pass over a waiting fetch count towards starvation.
        if (grant) begin
            if (owner == OWN_FETCH) begin
                starve_d = '0;
            end else if (fetch_req && !starved) begin
                starve_d = starve_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Owns the system-bus port: arbitrates fetch/load/store line transactions, runs the
// address and data beats, and routes tag-matched read responses back to the owner.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int DATA_W     = 64,
    parameter  int BEATS      = 8,
    parameter  int TAG_W      = 13,
    parameter  int STARVE_LIM = 4,
    localparam int BEAT_W     = $clog2(BEATS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [DATA_W-1:0] fetch_addr,
    input  logic              load_req,
    input  logic [DATA_W-1:0] load_addr,
    input  logic              store_req,
    input  logic [DATA_W-1:0] store_addr,
    input  logic [DATA_W-1:0] store_wdata,
    output logic [DATA_W-1:0] rd_data,
    output logic [2:0]        rd_valid,
    output logic [BEAT_W-1:0] beat_idx,
    output logic              fetch_done,
    output logic              load_done,
    output logic              store_done,
    output logic              bus_reqcyc,
    output logic [DATA_W-1:0] bus_req,
    output logic [TAG_W-1:0]  bus_reqtag,
    input  logic              bus_reqack,
    input  logic              bus_respcyc,
    input  logic [DATA_W-1:0] bus_resp,
    input  logic [TAG_W-1:0]  bus_resptag,
    output logic              bus_respack
);

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    owner_e              owner_q, owner_d;
    logic                rw_q, rw_d;
    logic [TAG_W-1:0]    tag_q, tag_d;

    owner_e              grant_owner;
    logic                grant;
    logic                arb_en;
    logic                last_beat;
    logic                grant_rw;

    assign arb_en    = (state_q == IDLE) && !reset;
    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
    assign grant_rw  = (grant_owner != OWN_STORE);
    assign beat_idx  = beat_q;

    mem_arb_prio #(
        .STARVE_LIM (STARVE_LIM)
    ) u_prio (
        .clk       (clk),
        .srst      (reset),
        .arb_en    (arb_en),
        .fetch_req (fetch_req),
        .load_req  (load_req),
        .store_req (store_req),
        .owner     (grant_owner),
        .grant     (grant)
    );

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        addr_d      = addr_q;
        owner_d     = owner_q;
        rw_d        = rw_q;
        tag_d       = tag_q;
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;
        rd_data     = '0;
        rd_valid    = 3'b000;
        fetch_done  = 1'b0;
        load_done   = 1'b0;
        store_done  = 1'b0;
        // Outputs are forced quiet while reset is held, whatever state the flops are in.
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        owner_d = grant_owner;
                        rw_d    = grant_rw;
                        tag_d   = {make_tag(grant_rw, grant_owner), {(TAG_W - TAG_HDR_W){1'b0}}};
                        beat_d  = '0;
                        state_d = ADDR;
                        case (grant_owner)
                            OWN_STORE: addr_d = store_addr;
                            OWN_LOAD:  addr_d = load_addr;
                            default:   addr_d = fetch_addr;
                        endcase
                    end
                end
                ADDR: begin
                    bus_reqcyc = 1'b1;
                    bus_req    = addr_q;
                    bus_reqtag = tag_q;
                    if (bus_reqack) begin
                        beat_d  = '0;
                        state_d = rw_q ? RD_WAIT : WR_DATA;
                    end
                end
                WR_DATA: begin
                    bus_reqcyc = 1'b1;
                    bus_req    = store_wdata;
                    bus_reqtag = tag_q;
                    if (bus_reqack) begin
                        beat_d = beat_q + BEAT_W'(1);
                        if (last_beat) begin
                            state_d = DONE;
                        end
                    end
                end
                RD_WAIT: begin
                    // Beats carrying someone else's tag are left for their owner.
                    if (bus_respcyc && (bus_resptag == tag_q)) begin
                        bus_respack = 1'b1;
                        rd_data     = bus_resp;
                        rd_valid    = owner_onehot(owner_q);
                        beat_d      = beat_q + BEAT_W'(1);
                        if (last_beat) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    {fetch_done, load_done, store_done} = owner_onehot(owner_q);
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
            owner_q <= OWN_FETCH;
            rw_q    <= 1'b0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            owner_q <= owner_d;
            rw_q    <= rw_d;
            tag_q   <= tag_d;
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: arbitration table, directed corner sequences,
// and randomized traffic against a transaction-level arbitration model.
module tb_mem_req_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req, load_req, store_req;
    logic [63:0] fetch_addr, load_addr, store_addr, store_wdata;
    logic [63:0] rd_data;
    logic [2:0]  rd_valid;
    logic [2:0]  beat_idx;
    logic        fetch_done, load_done, store_done;
    logic        bus_reqcyc;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_reqack;
    logic        bus_respcyc;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
    logic        bus_respack;

    logic [63:0] addr_of [3];
    logic [63:0] store_line [8];

    int n_checks = 0;
    int n_err    = 0;
    int last_wait;
    int starve_m;

    localparam logic [63:0] A_F = 64'h1000;
    localparam logic [63:0] A_L = 64'h2040;
    localparam logic [63:0] A_S = 64'h3080;

    always #5 clk = ~clk;

    assign fetch_addr  = addr_of[0];
    assign load_addr   = addr_of[1];
    assign store_addr  = addr_of[2];
    assign store_wdata = store_line[beat_idx];

    mem_req_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .load_req    (load_req),
        .load_addr   (load_addr),
        .store_req   (store_req),
        .store_addr  (store_addr),
        .store_wdata (store_wdata),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .beat_idx    (beat_idx),
        .fetch_done  (fetch_done),
        .load_done   (load_done),
        .store_done  (store_done),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag),
        .bus_respack (bus_respack)
    );

    typedef struct {
        logic        f, l, s;
        logic [12:0] tag;
        logic [63:0] addr;
        logic [2:0]  done;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Tag format {rw(1=read), owner[1:0], 10 zero bits}; owner 0=fetch,1=load,2=store.
    function automatic logic [12:0] exp_tag(input int own);
        logic       rw;
        logic [1:0] o;
        rw = (own != 2);
        o  = 2'(own);
        return {rw, o, 10'b0};
    endfunction

    function automatic logic [2:0] onehot(input int own);
        return 3'b100 >> own;
    endfunction

    function automatic int model_pick(input logic f, input logic l, input logic s);
        if (starve_m == 4 && f) return 0;
        if (s) return 2;
        if (l) return 1;
        return 0;
    endfunction

    function automatic void model_grant(input int own, input logic f);
        if (own == 0) starve_m = 0;
        else if (f && starve_m < 4) starve_m++;
    endfunction

    task automatic set_reqs(input logic f, input logic l, input logic s);
        fetch_req = f;
        load_req  = l;
        store_req = s;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
        set_reqs(0, 0, 0);
        step();
        step();
        reset    = 1'b0;
        starve_m = 0;
    endtask

    // Plays the bus side of one transaction and checks it end to end; returns in the IDLE cycle.
    task automatic run_txn(input logic [12:0] etag, input logic [63:0] eaddr, input logic [2:0] eone,
                           input int ack_dly, input bit foreign, input bit fixed);
        int          n;
        logic [63:0] d;
        n = 0;
        while (bus_reqcyc !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        last_wait = n;
        chk("addr_phase_seen", 64'(bus_reqcyc), 64'd1);
        if (bus_reqcyc !== 1'b1) return;
        chk("addr", bus_req, eaddr);
        chk("reqtag", 64'(bus_reqtag), 64'(etag));
        repeat (ack_dly) begin
            step();
            chk("addr_hold_cyc", 64'(bus_reqcyc), 64'd1);
            chk("addr_hold", bus_req, eaddr);
        end
        bus_reqack = 1'b1;
        step();
        bus_reqack = 1'b0;
        if (!etag[12]) begin
            for (int b = 0; b < 8; b++) begin
                chk("wr_cyc", 64'(bus_reqcyc), 64'd1);
                chk("wr_data", bus_req, store_line[b]);
                chk("wr_beat", 64'(beat_idx), 64'(b));
                if ($urandom_range(0, 1) == 1) begin
                    step();
                    chk("wr_hold", bus_req, store_line[b]);
                end
                bus_reqack = 1'b1;
                step();
                bus_reqack = 1'b0;
            end
        end else begin
            for (int b = 0; b < 8; b++) begin
                d = fixed ? 64'hA0 + 64'(b) : {$urandom(), $urandom()};
                if (foreign && b == 3) begin
                    bus_respcyc = 1'b1;
                    bus_resptag = 13'h1FFF;
                    bus_resp    = ~d;
                    #1;
                    chk("foreign_respack", 64'(bus_respack), 64'd0);
                    chk("foreign_rd_valid", 64'(rd_valid), 64'd0);
                    step();
                    chk("foreign_beat", 64'(beat_idx), 64'd3);
                end
                if (!fixed && $urandom_range(0, 2) == 0) begin
                    bus_respcyc = 1'b0;
                    #1;
                    chk("gap_rd_valid", 64'(rd_valid), 64'd0);
                    step();
                end
                bus_respcyc = 1'b1;
                bus_resptag = etag;
                bus_resp    = d;
                #1;
                chk("respack", 64'(bus_respack), 64'd1);
                chk("rd_valid", 64'(rd_valid), 64'(eone));
                chk("rd_data", rd_data, d);
                chk("rd_beat", 64'(beat_idx), 64'(b));
                step();
                bus_respcyc = 1'b0;
            end
        end
        chk("done", 64'({fetch_done, load_done, store_done}), 64'(eone));
        chk("done_reqcyc", 64'(bus_reqcyc), 64'd0);
        step();
        chk("idle_done", 64'({fetch_done, load_done, store_done}), 64'd0);
        chk("idle_reqcyc", 64'(bus_reqcyc), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          own;
        logic        pend [3];
        logic [63:0] ra;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 13'h1000, A_F, 3'b100};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 13'h1400, A_L, 3'b010};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 13'h0800, A_S, 3'b001};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 13'h1400, A_L, 3'b010};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 13'h0800, A_S, 3'b001};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 13'h0800, A_S, 3'b001};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 13'h0800, A_S, 3'b001};

        addr_of[0] = A_F;
        addr_of[1] = A_L;
        addr_of[2] = A_S;
        for (int i = 0; i < 8; i++) store_line[i] = {$urandom(), $urandom()};
        bus_resp    = '0;
        bus_resptag = '0;
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;

        // Reset held with every request raised: bus stays quiet.
        reset = 1'b1;
        set_reqs(1, 1, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_reqcyc", 64'(bus_reqcyc), 64'd0);
            chk("rst_done", 64'({fetch_done, load_done, store_done}), 64'd0);
            chk("rst_rd_valid", 64'(rd_valid), 64'd0);
            chk("rst_respack", 64'(bus_respack), 64'd0);
        end
        reset = 1'b0;
        set_reqs(0, 0, 0);
        starve_m = 0;
        step();
        chk("post_rst_reqcyc", 64'(bus_reqcyc), 64'd0);
        chk("post_rst_beat", 64'(beat_idx), 64'd0);

        // Single-transaction arbitration table.
        foreach (vecs[i]) begin
            do_reset();
            set_reqs(vecs[i].f, vecs[i].l, vecs[i].s);
            run_txn(vecs[i].tag, vecs[i].addr, vecs[i].done, 1, 0, 0);
            set_reqs(0, 0, 0);
        end

        // Fetch line read, ack after 2 cycles, data A0..A7.
        do_reset();
        set_reqs(1, 0, 0);
        run_txn(13'h1000, 64'h1000, 3'b100, 2, 0, 1);
        set_reqs(0, 0, 0);

        // All three at once: store, then load, then fetch, back to back.
        do_reset();
        set_reqs(1, 1, 1);
        run_txn(13'h0800, A_S, 3'b001, 1, 0, 0);
        set_reqs(1, 1, 0);
        run_txn(13'h1400, A_L, 3'b010, 0, 0, 0);
        chk("b2b_gap_load", 64'(last_wait), 64'd1);
        set_reqs(1, 0, 0);
        run_txn(13'h1000, A_F, 3'b100, 0, 0, 0);
        chk("b2b_gap_fetch", 64'(last_wait), 64'd1);
        set_reqs(0, 0, 0);

        // Starvation: four loads pass a waiting fetch, then fetch is forced, then the count restarts.
        do_reset();
        set_reqs(1, 1, 0);
        for (int i = 0; i < 4; i++) run_txn(13'h1400, A_L, 3'b010, 0, 0, 0);
        run_txn(13'h1000, A_F, 3'b100, 0, 0, 0);
        run_txn(13'h1400, A_L, 3'b010, 0, 0, 0);
        set_reqs(0, 0, 0);

        // Foreign response tag in the middle of a load read.
        do_reset();
        set_reqs(0, 1, 0);
        run_txn(13'h1400, A_L, 3'b010, 0, 1, 0);
        set_reqs(0, 0, 0);

        // Reset during read beat 3 aborts silently; the held request then runs normally.
        do_reset();
        set_reqs(0, 1, 0);
        step();
        chk("abort_addr_cyc", 64'(bus_reqcyc), 64'd1);
        bus_reqack = 1'b1;
        step();
        bus_reqack = 1'b0;
        for (int b = 0; b < 3; b++) begin
            bus_respcyc = 1'b1;
            bus_resptag = 13'h1400;
            bus_resp    = 64'(b);
            step();
        end
        chk("abort_pre_beat", 64'(beat_idx), 64'd3);
        reset = 1'b1;
        step();
        reset       = 1'b0;
        bus_respcyc = 1'b0;
        starve_m    = 0;
        #1;
        chk("abort_idle_reqcyc", 64'(bus_reqcyc), 64'd0);
        chk("abort_beat", 64'(beat_idx), 64'd0);
        chk("abort_no_done", 64'(load_done), 64'd0);
        run_txn(13'h1400, A_L, 3'b010, 1, 0, 0);
        set_reqs(0, 0, 0);

        // Randomized traffic against the arbitration model.
        do_reset();
        for (int i = 0; i < 3; i++) pend[i] = 1'b0;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    ra = {$urandom(), $urandom()};
                    addr_of[i] = ra & ~64'h3F;
                    if (i == 2) for (int k = 0; k < 8; k++) store_line[k] = {$urandom(), $urandom()};
                end
            end
            if (!pend[0] && !pend[1] && !pend[2]) pend[$urandom_range(0, 1)] = 1'b1;
            set_reqs(pend[0], pend[1], pend[2]);
            own = model_pick(pend[0], pend[1], pend[2]);
            model_grant(own, pend[0]);
            run_txn(exp_tag(own), addr_of[own], onehot(own), $urandom_range(0, 2),
                    $urandom_range(0, 3) == 0, 0);
            pend[own] = 1'b0;
            set_reqs(pend[0], pend[1], pend[2]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
